// File: rtl/mc_pkg.sv
// mc_pkg: shared constants and types for the multicycle MIPS control unit.
//   - opcode / funct field values decoded by the FSM and the ALU decoder
//   - ALU select codes, ALUOp codes, ALU B-source and PC-source encodings
//   - state_t: FSM state encoding 0..12 (BNEEX = 12 exists only for MC_BNE_EN)
//   - ctrl_t + state_ctrl(): Moore control word produced by each state
// Optional feature macro: MC_BNE_EN (adds the bne instruction via BNEEX).
package mc_pkg;

  localparam int OP_W = 6;

  // Opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  // ALU select
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOp from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B source
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       bne;      // branch taken on ~zero instead of zero
    logic [1:0] aluop;
  } ctrl_t;

  // Control word for a state; everything not listed stays 0.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.pcsrc   = PC_ALU;
        c.pcwrite = 1'b1;
        c.aluop   = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_IMM_SH;  // branch target precomputed into ALUOut
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REG;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_BEQEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PC_ALUOUT;
        c.branch  = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PC_ALUOUT;
        c.branch  = 1'b1;
        c.bne     = 1'b1;
      end
`endif
      S_JEX: begin
        c.pcsrc   = PC_JUMP;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_alu_decoder.sv
// alu_decoder: combinational mapping of ALUOp and funct to the ALU select.
//   aluop      in  2  00 add, 01 sub, 10 decode funct
//   funct      in  6  IR[5:0]
//   alucontrol out 3  ALU select
// Unknown funct (and the unused ALUOp 11) fall back to ADD.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0]      aluop,
  input  logic [OP_W-1:0] funct,
  output logic [2:0]      alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: Moore control FSM for the Lab10 multicycle MIPS datapath.
// Ports:
//   clk, reset (sync, active-high -> FETCH)
//   op, funct  : IR[31:26], IR[5:0]
//   zero       : ALU zero flag, used combinationally for pcen
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
//   alusrcb[1:0], pcsrc[1:0] : registered Moore controls
//   pcen       : pcwrite | (branch & zero)  (inverted zero in BNEEX)
//   alucontrol : from alu_decoder; follows funct live while in RTYPEEX
//   state_o    : current state encoding (debug)
// Optional feature macro: MC_BNE_EN adds bne (op 000101) via state BNEEX.
// The control word is computed from the next state and registered alongside
// it, so every output flop always equals state_ctrl(state_q).
module mc_control
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  output logic           iord,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic           pcen,
  output logic [2:0]     alucontrol,
  output logic [3:0]     state_o
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default:      state_d = S_FETCH;  // illegal op: NOP
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      // MEMWB, MEMWR, RTYPEWB, BEQEX, BNEEX, ADDIWB, JEX and any unused
      // encoding all return to FETCH.
      default:   state_d = S_FETCH;
    endcase
    ctrl_d = state_ctrl(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  alu_decoder u_alu_decoder (
    .aluop      (ctrl_q.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  assign iord     = ctrl_q.iord;
  assign memwrite = ctrl_q.memwrite;
  assign irwrite  = ctrl_q.irwrite;
  assign regdst   = ctrl_q.regdst;
  assign memtoreg = ctrl_q.memtoreg;
  assign regwrite = ctrl_q.regwrite;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;
  // bne flips the sense of zero; it is 0 for every other state.
  assign pcen     = ctrl_q.pcwrite | (ctrl_q.branch & (zero ^ ctrl_q.bne));
  assign state_o  = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed bench for mc_control; expected values hand-derived.
module tb_mc_control;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  mc_control #(.OPW(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .state_o    (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_state(input string tag, input logic [3:0] exp_state);
    tick();
    check(tag, {28'd0, state_o}, {28'd0, exp_state});
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    funct = 6'b100000;
    zero  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state = FETCH with FETCH controls
    check("rst_state",  {28'd0, state_o}, 32'd0);
    check("rst_irwrite", {31'd0, irwrite}, 32'd1);
    check("rst_pcen",    {31'd0, pcen}, 32'd1);
    check("rst_alucon",  {29'd0, alucontrol}, 32'b010);
    check("rst_srcb",    {30'd0, alusrcb}, 32'b01);
    check("rst_others",  {26'd0, iord, memwrite, regdst, memtoreg, regwrite, alusrca}, 32'd0);
    check("rst_pcsrc",   {30'd0, pcsrc}, 32'b00);

    // R-type
    tick_state("r_decode", 4'd1);
    check("dec_srcb",   {30'd0, alusrcb}, 32'b11);
    check("dec_alucon", {29'd0, alucontrol}, 32'b010);
    check("dec_pcen",   {31'd0, pcen}, 32'd0);
    check("dec_irwrite", {31'd0, irwrite}, 32'd0);
    tick_state("r_ex", 4'd6);
    check("rex_srca", {31'd0, alusrca}, 32'd1);
    check("rex_srcb", {30'd0, alusrcb}, 32'b00);
    check("rex_add",  {29'd0, alucontrol}, 32'b010);
    funct = 6'b100010; #1; check("rex_sub", {29'd0, alucontrol}, 32'b110);
    funct = 6'b100100; #1; check("rex_and", {29'd0, alucontrol}, 32'b000);
    funct = 6'b100101; #1; check("rex_or",  {29'd0, alucontrol}, 32'b001);
    funct = 6'b101010; #1; check("rex_slt", {29'd0, alucontrol}, 32'b111);
    funct = 6'b111111; #1; check("rex_unk", {29'd0, alucontrol}, 32'b010);
    tick_state("r_wb", 4'd7);
    check("rwb_regdst",   {31'd0, regdst}, 32'd1);
    check("rwb_regwrite", {31'd0, regwrite}, 32'd1);
    tick_state("r_fetch", 4'd0);

    // lw
    op = 6'b100011;
    funct = 6'b100000;
    tick_state("lw_decode", 4'd1);
    tick_state("lw_memadr", 4'd2);
    check("lw_adr_srca", {31'd0, alusrca}, 32'd1);
    check("lw_adr_srcb", {30'd0, alusrcb}, 32'b10);
    check("lw_adr_alu",  {29'd0, alucontrol}, 32'b010);
    tick_state("lw_memrd", 4'd3);
    check("lw_rd_iord", {31'd0, iord}, 32'd1);
    check("lw_rd_mw",   {31'd0, memwrite}, 32'd0);
    tick_state("lw_memwb", 4'd4);
    check("lw_wb_rw",  {31'd0, regwrite}, 32'd1);
    check("lw_wb_m2r", {31'd0, memtoreg}, 32'd1);
    tick_state("lw_fetch", 4'd0);

    // sw
    op = 6'b101011;
    tick_state("sw_decode", 4'd1);
    check("sw_dec_rw", {31'd0, regwrite}, 32'd0);
    tick_state("sw_memadr", 4'd2);
    check("sw_adr_rw", {31'd0, regwrite}, 32'd0);
    tick_state("sw_memwr", 4'd5);
    check("sw_wr_mw",   {31'd0, memwrite}, 32'd1);
    check("sw_wr_iord", {31'd0, iord}, 32'd1);
    check("sw_wr_rw",   {31'd0, regwrite}, 32'd0);
    tick_state("sw_fetch", 4'd0);

    // beq
    op = 6'b000100;
    zero = 1'b1;
    tick_state("beq_decode", 4'd1);
    check("beq_dec_pcen", {31'd0, pcen}, 32'd0);
    tick_state("beq_ex", 4'd8);
    check("beq_pcen_z1", {31'd0, pcen}, 32'd1);
    check("beq_pcsrc",   {30'd0, pcsrc}, 32'b01);
    check("beq_alu",     {29'd0, alucontrol}, 32'b110);
    check("beq_srca",    {31'd0, alusrca}, 32'd1);
    zero = 1'b0; #1;
    check("beq_pcen_z0", {31'd0, pcen}, 32'd0);
    tick_state("beq_fetch", 4'd0);

    // bne
    op = 6'b000101;
    tick_state("bne_decode", 4'd1);
`ifdef MC_BNE_EN
    tick_state("bne_ex", 4'd12);
    check("bne_pcen_z0", {31'd0, pcen}, 32'd1);
    check("bne_pcsrc",   {30'd0, pcsrc}, 32'b01);
    zero = 1'b1; #1;
    check("bne_pcen_z1", {31'd0, pcen}, 32'd0);
    zero = 1'b0;
    tick_state("bne_fetch", 4'd0);
`else
    tick_state("bne_illegal", 4'd0);
`endif

    // addi
    op = 6'b001000;
    tick_state("addi_decode", 4'd1);
    tick_state("addi_ex", 4'd9);
    check("addi_srca", {31'd0, alusrca}, 32'd1);
    check("addi_srcb", {30'd0, alusrcb}, 32'b10);
    tick_state("addi_wb", 4'd10);
    check("addi_rw",     {31'd0, regwrite}, 32'd1);
    check("addi_regdst", {31'd0, regdst}, 32'd0);
    check("addi_m2r",    {31'd0, memtoreg}, 32'd0);
    tick_state("addi_fetch", 4'd0);

    // j
    op = 6'b000010;
    tick_state("j_decode", 4'd1);
    tick_state("j_ex", 4'd11);
    check("j_pcsrc", {30'd0, pcsrc}, 32'b10);
    check("j_pcen",  {31'd0, pcen}, 32'd1);
    tick_state("j_fetch", 4'd0);

    // illegal op
    op = 6'b111111;
    tick_state("ill_decode", 4'd1);
    check("ill_dec_w", {30'd0, regwrite, memwrite}, 32'd0);
    tick_state("ill_fetch", 4'd0);
    check("ill_fet_w", {30'd0, regwrite, memwrite}, 32'd0);

    // reset during MEMRD aborts lw
    op = 6'b100011;
    tick_state("abort_decode", 4'd1);
    tick_state("abort_memadr", 4'd2);
    tick_state("abort_memrd", 4'd3);
    reset = 1'b1;
    tick_state("abort_fetch", 4'd0);
    check("abort_no_wb", {31'd0, regwrite}, 32'd0);
    check("abort_irw",   {31'd0, irwrite}, 32'd1);
    reset = 1'b0;
    tick_state("abort_restart", 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
